cache: RTL and testbench
========================

CACHE -- requirements
Module: cache

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are clk and reset.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 addr  input  6  read word address (main memory word index 0-63).
REQ-005 waddr  input  6  write word address.
REQ-006 RW  input  1  operation type: 1 = read, 0 = write.
REQ-007 CS  input  1  chip select; a request is ignored while CS=0.
REQ-008 start  input  1  request strobe; sampled only when the controller is IDLE.
REQ-009 wdata  input  32  write data.
REQ-010 data  output  32  registered read data; holds its last value between reads.
REQ-011 STALL  output  1  registered; 1 while a read miss is being serviced.

Function
REQ-012 Backing store SHALL be a submodule instance named M holding array mem[0:63] of 32-bit words, hierarchically writable as M.mem[k]; it has no reset.
REQ-013 Cache organisation SHALL be 2-way set-associative, 4 sets, 1-word lines: index = addr[1:0], tag = addr[5:2]; each way has a valid bit, a 4-bit tag and a 32-bit word; each set has one LRU bit naming the way to replace.
REQ-014 States SHALL be IDLE, LOOKUP, MISS (3 cycles), FILL.
REQ-015 IDLE: on an edge with start=1 and CS=1, latch addr, waddr, wdata and RW, then go to LOOKUP; otherwise stay in IDLE.
REQ-016 start is ignored in every state other than IDLE; there is no request queue.
REQ-017 Read hit in LOOKUP: data <= hit way word; LRU <= other way; go to IDLE; STALL stays 0 (latency 2 edges from acceptance).
REQ-018 Read miss in LOOKUP: STALL <= 1; go to MISS; after 3 MISS cycles go to FILL.
REQ-019 FILL: victim is the invalid way (way 0 if both are invalid), else the LRU way; write tag/word from M.mem[addr], set valid, LRU <= other way, data <= M.mem[addr], STALL <= 0, go to IDLE.
REQ-020 Write in LOOKUP: M.mem[waddr] <= wdata (write-through); on hit, the way word is updated too and LRU <= other way; go to IDLE; STALL stays 0.
REQ-021 Write miss without REQ-028: the cache is not modified.
REQ-022 A start/CS=1 on the same edge the FSM returns to IDLE SHALL NOT be accepted; acceptance needs IDLE before the edge.
REQ-023 Both ways SHALL never hold the same valid tag within one set.

Reset
REQ-024 reset=0 SHALL immediately force IDLE, all valid bits 0, all LRU bits 0, data=0, STALL=0.
REQ-025 Reset during MISS/FILL SHALL abort the operation; no line is filled and data stays 0.
REQ-026 M.mem contents SHALL be unaffected by reset.

Configuration
REQ-027 Macro CACHE_WRITE_ALLOCATE_EN selects the write-miss policy.
REQ-028 Defined: on a write miss, the victim way (REQ-019 rule) is loaded with tag/wdata, valid set, LRU <= other way; no stall is added. Undefined: REQ-021 applies.

Verification
REQ-029 Preload M.mem[k]=k, reset pulse, read addr=5 -> STALL=1 for 4 cycles, then data=5, STALL=0.
REQ-030 Read addr=5 again -> data=5 two edges after acceptance, STALL never asserted.
REQ-031 Read 1, 5, 9 (all set 1), then 5 (hit), then 1 -> 9 evicts 1; the final read of 1 misses (STALL) and returns data=1.
REQ-032 Write waddr=5, wdata=32'hDEADBEEF after 5 is cached -> M.mem[5]=32'hDEADBEEF; read 5 hits, data=32'hDEADBEEF, no stall.
REQ-033 Assert reset in the 2nd MISS cycle of a read of addr=7 -> STALL=0 and data=0 at once; a later read of 7 misses again.
REQ-034 start=1 with CS=0 for 5 cycles -> no state change, STALL=0, data unchanged; write miss to 12 -> with macro, read 12 hits; without it, read 12 misses.

Source files
------------

// File: rtl/cache.sv
// Two-way set-associative, write-through cache in front of a 64-word memory.
// 4 sets, 1-word lines, index = addr[1:0], tag = addr[5:2], one LRU bit per set.
// Optional feature macro: CACHE_WRITE_ALLOCATE_EN (allocate a line on write miss).

// Backing store; no reset so contents survive a cache reset.
module cache_mem (
    input  logic        clk,
    input  logic        we,
    input  logic [5:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [5:0]  raddr,
    output logic [31:0] rdata
);
    logic [31:0] mem [0:63];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

module cache (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  addr,
    input  logic [5:0]  waddr,
    input  logic        RW,
    input  logic        CS,
    input  logic        start,
    input  logic [31:0] wdata,
    output logic [31:0] data,
    output logic        STALL
);
    typedef enum logic [1:0] {IDLE, LOOKUP, MISS, FILL} state_t;

    state_t      state, state_nx;
    logic [1:0]  mcnt;
    logic [5:0]  addr_q, waddr_q;
    logic [31:0] wdata_q;
    logic        rw_q;

    logic [3:0]  valid [2];
    logic [3:0]  tagm  [2][4];
    logic [31:0] wordm [2][4];
    logic [3:0]  lru;

    logic [5:0]  la;
    logic [1:0]  idx;
    logic [3:0]  tg;
    logic        hit0, hit1, hit, hway, victim;
    logic        mem_we;
    logic [31:0] mem_rdata;

    cache_mem M (
        .clk   (clk),
        .we    (mem_we),
        .waddr (waddr_q),
        .wdata (wdata_q),
        .raddr (addr_q),
        .rdata (mem_rdata)
    );

    // Tag compare and victim choice for the latched request
    always_comb begin
        la     = rw_q ? addr_q : waddr_q;
        idx    = la[1:0];
        tg     = la[5:2];
        hit0   = valid[0][idx] && (tagm[0][idx] == tg);
        hit1   = valid[1][idx] && (tagm[1][idx] == tg);
        hit    = hit0 | hit1;
        hway   = hit1;
        if (!valid[0][idx])      victim = 1'b0;
        else if (!valid[1][idx]) victim = 1'b1;
        else                     victim = lru[idx];
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic and memory write strobe
    always_comb begin
        state_nx = state;
        mem_we   = 1'b0;
        case (state)
            IDLE:   if (start && CS) state_nx = LOOKUP;
            LOOKUP: begin
                if (rw_q) begin
                    state_nx = hit ? IDLE : MISS;
                end else begin
                    mem_we   = 1'b1;
                    state_nx = IDLE;
                end
            end
            MISS:   if (mcnt == 2'd2) state_nx = FILL;
            FILL:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, outputs, valid and LRU bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            rw_q     <= 1'b0;
            mcnt     <= '0;
            data     <= '0;
            STALL    <= 1'b0;
            valid[0] <= '0;
            valid[1] <= '0;
            lru      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && CS) begin
                        addr_q  <= addr;
                        waddr_q <= waddr;
                        wdata_q <= wdata;
                        rw_q    <= RW;
                    end
                end
                LOOKUP: begin
                    if (rw_q) begin
                        if (hit) begin
                            data     <= wordm[hway][idx];
                            lru[idx] <= ~hway;
                        end else begin
                            STALL <= 1'b1;
                            mcnt  <= '0;
                        end
                    end else if (hit) begin
                        lru[idx] <= ~hway;
                    end
`ifdef CACHE_WRITE_ALLOCATE_EN
                    else begin
                        valid[victim][idx] <= 1'b1;
                        lru[idx]           <= ~victim;
                    end
`endif
                end
                MISS: mcnt <= mcnt + 2'd1;
                FILL: begin
                    valid[victim][idx] <= 1'b1;
                    lru[idx]           <= ~victim;
                    data               <= mem_rdata;
                    STALL              <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag and word storage; gated by the FSM, so it needs no reset
    always_ff @(posedge clk) begin
        if (state == LOOKUP && !rw_q) begin
            if (hit) begin
                wordm[hway][idx] <= wdata_q;
            end
`ifdef CACHE_WRITE_ALLOCATE_EN
            else begin
                tagm[victim][idx]  <= tg;
                wordm[victim][idx] <= wdata_q;
            end
`endif
        end else if (state == FILL) begin
            tagm[victim][idx]  <= tg;
            wordm[victim][idx] <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_cache.sv
// Directed bench for cache with a transaction-level cache/memory model.
// Honors CACHE_WRITE_ALLOCATE_EN the same way as the design.
module tb_cache;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  addr = '0;
    logic [5:0]  waddr = '0;
    logic        RW = 1'b1;
    logic        CS = 1'b0;
    logic        start = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] data;
    logic        STALL;

    cache dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .waddr (waddr),
        .RW    (RW),
        .CS    (CS),
        .start (start),
        .wdata (wdata),
        .data  (data),
        .STALL (STALL)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int stall_cycles = 0;
    logic [31:0] exp_data = '0;
    logic        exp_stall = 1'b0;

    // Model: per set/way contents, replacement bit, memory image
    bit          m_valid [2][4];
    logic [3:0]  m_tag   [2][4];
    logic [31:0] m_word  [2][4];
    bit          m_lru   [4];
    logic [31:0] m_mem   [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int m_find(input int s, input logic [3:0] t);
        for (int w = 0; w < 2; w++)
            if (m_valid[w][s] && m_tag[w][s] == t) return w;
        return -1;
    endfunction

    function automatic int m_victim(input int s);
        if (!m_valid[0][s]) return 0;
        if (!m_valid[1][s]) return 1;
        return m_lru[s] ? 1 : 0;
    endfunction

    task automatic m_reset();
        for (int s = 0; s < 4; s++) begin
            m_valid[0][s] = 1'b0;
            m_valid[1][s] = 1'b0;
            m_lru[s] = 1'b0;
        end
        exp_data  = '0;
        exp_stall = 1'b0;
    endtask

    // Every cycle outside reset, outputs must match the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", {31'd0, STALL}, {31'd0, exp_stall});
            check("data", data, exp_data);
            if (STALL) stall_cycles++;
        end
    end

    task automatic rd(input logic [5:0] a, input bit abort, input bit busy);
        int s, w, v;
        logic [3:0] t;
        s = int'(a[1:0]);
        t = a[5:2];
        @(negedge clk);
        addr = a; RW = 1'b1; CS = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; CS = 1'b0;
        w = m_find(s, t);
        @(posedge clk); #1;
        if (w >= 0) begin
            exp_data = m_word[w][s];
            m_lru[s] = (w == 0);
            return;
        end
        exp_stall = 1'b1;
        if (busy) begin
            addr = 6'd62; RW = 1'b1; CS = 1'b1; start = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (abort && k == 0) begin
                reset = 1'b0;
                m_reset();
                #1;
                check("abort_stall", {31'd0, STALL}, 32'd0);
                check("abort_data", data, 32'd0);
                @(negedge clk); @(negedge clk);
                reset = 1'b1;
                return;
            end
        end
        @(posedge clk); #1;
        start = 1'b0; CS = 1'b0;
        v = m_victim(s);
        m_valid[v][s] = 1'b1;
        m_tag[v][s]   = t;
        m_word[v][s]  = m_mem[a];
        m_lru[s]      = (v == 0);
        exp_stall = 1'b0;
        exp_data  = m_mem[a];
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        int s, w, v;
        logic [3:0] t;
        s = int'(a[1:0]);
        t = a[5:2];
        @(negedge clk);
        waddr = a; wdata = d; RW = 1'b0; CS = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; CS = 1'b0; RW = 1'b1;
        w = m_find(s, t);
        @(posedge clk); #1;
        m_mem[a] = d;
        if (w >= 0) begin
            m_word[w][s] = d;
            m_lru[s] = (w == 0);
        end
`ifdef CACHE_WRITE_ALLOCATE_EN
        else begin
            v = m_victim(s);
            m_valid[v][s] = 1'b1;
            m_tag[v][s]   = t;
            m_word[v][s]  = d;
            m_lru[s]      = (v == 0);
        end
`else
        v = 0;
`endif
        check("mem_write", dut.M.mem[a], d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 64; k++) begin
            dut.M.mem[k] = 32'(k);
            m_mem[k] = 32'(k);
        end
        m_reset();
        #2;
        check("rst_stall", {31'd0, STALL}, 32'd0);
        check("rst_data", data, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // First read of 5 misses
        stall_cycles = 0;
        rd(6'd5, 1'b0, 1'b0);
        idle(1);
        check("miss5_cycles", 32'(stall_cycles), 32'd4);
        check("miss5_data", data, 32'd5);

        // Second read of 5 hits
        stall_cycles = 0;
        rd(6'd5, 1'b0, 1'b0);
        idle(1);
        check("hit5_cycles", 32'(stall_cycles), 32'd0);
        check("hit5_data", data, 32'd5);

        // LRU in set 1: 1, 5, 9, 5, then 1 must miss
        rd(6'd1, 1'b0, 1'b0);
        check("rd1_data", data, 32'd1);
        rd(6'd5, 1'b0, 1'b0);
        rd(6'd9, 1'b0, 1'b0);
        check("rd9_data", data, 32'd9);
        stall_cycles = 0;
        rd(6'd5, 1'b0, 1'b0);
        check("rd5_lru_cycles", 32'(stall_cycles), 32'd0);
        stall_cycles = 0;
        rd(6'd1, 1'b0, 1'b0);
        idle(1);
        check("rd1_evicted_cycles", 32'(stall_cycles), 32'd4);
        check("rd1_evicted_data", data, 32'd1);

        // Write-through hit
        wr(6'd5, 32'hDEADBEEF);
        stall_cycles = 0;
        rd(6'd5, 1'b0, 1'b0);
        idle(1);
        check("wr_hit_cycles", 32'(stall_cycles), 32'd0);
        check("wr_hit_data", data, 32'hDEADBEEF);

        // Reset during second MISS cycle of read 7
        rd(6'd7, 1'b1, 1'b0);
        idle(1);
        check("mem_survives_reset", dut.M.mem[5], 32'hDEADBEEF);
        check("post_abort_data", data, 32'd0);
        stall_cycles = 0;
        rd(6'd7, 1'b0, 1'b1);
        idle(4);
        check("rd7_again_cycles", 32'(stall_cycles), 32'd4);
        check("rd7_again_data", data, 32'd7);

        // start with CS low is ignored
        stall_cycles = 0;
        @(negedge clk);
        addr = 6'd62; RW = 1'b1; CS = 1'b0; start = 1'b1;
        idle(5);
        start = 1'b0;
        idle(2);
        check("cs0_cycles", 32'(stall_cycles), 32'd0);
        check("cs0_data", data, 32'd7);

        // Write miss to 12, then read 12
        wr(6'd12, 32'h000000C5);
        stall_cycles = 0;
        rd(6'd12, 1'b0, 1'b0);
        idle(1);
`ifdef CACHE_WRITE_ALLOCATE_EN
        check("wmiss_rd12_cycles", 32'(stall_cycles), 32'd0);
`else
        check("wmiss_rd12_cycles", 32'(stall_cycles), 32'd4);
`endif
        check("wmiss_rd12_data", data, 32'h000000C5);
        stall_cycles = 0;
        rd(6'd12, 1'b0, 1'b0);
        idle(2);
        check("rd12_hit_cycles", 32'(stall_cycles), 32'd0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
